// File: rtl/fec_pkg.sv
// Definitions shared by the FEC arithmetic units (squarer and square-root unit).
// The state codes double as the externally visible state_o values.
package fec_pkg;

  localparam logic [2:0] ST_READY = 3'd0;
  localparam logic [2:0] ST_WORK  = 3'd1;
  localparam logic [2:0] ST_DONE  = 3'd2;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [2:0] {
    StReady = ST_READY,
    StWork  = ST_WORK,
    StDone  = ST_DONE
  } state_e;

endpackage

// File: rtl/square_step.sv
// One combinational shift-add multiplier step, kept separate so an unrolled
// squarer can chain several of these per clock.
module square_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0]   mplier,
  input  logic [2*WIDTH-1:0] acc,
  output logic [2*WIDTH-1:0] mcand_nxt,
  output logic [WIDTH-1:0]   mplier_nxt,
  output logic [2*WIDTH-1:0] acc_nxt
);

  always_comb begin
    // The sum never overflows because x*x < 2**(2*WIDTH).
    acc_nxt    = mplier[0] ? (acc + mcand) : acc;
    mcand_nxt  = mcand << 1;
    mplier_nxt = mplier >> 1;
  end

endmodule

// File: rtl/square.sv
// Iterative unsigned squarer: y = x*x, one multiplier bit retired per clock,
// fixed latency of WIDTH cycles from the accepting edge to a valid result.
module square
  import fec_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   x_bi,
  output logic [2*WIDTH-1:0] y_bo,
  output logic [2:0]         state_o
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e              state_q;
  logic [2*WIDTH-1:0]  mcand_q;
  logic [WIDTH-1:0]    mplier_q;
  logic [2*WIDTH-1:0]  acc_q;
  logic [CntW-1:0]     cnt_q;

  logic [2*WIDTH-1:0]  mcand_nxt;
  logic [WIDTH-1:0]    mplier_nxt;
  logic [2*WIDTH-1:0]  acc_nxt;

  square_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .mcand      (mcand_q),
    .mplier     (mplier_q),
    .acc        (acc_q),
    .mcand_nxt  (mcand_nxt),
    .mplier_nxt (mplier_nxt),
    .acc_nxt    (acc_nxt)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StReady;
      state_o  <= ST_READY;
      y_bo     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        // DONE re-accepts like READY so back-to-back operations skip READY.
        StReady, StDone: begin
          if (start_i) begin
            mcand_q  <= {{WIDTH{1'b0}}, x_bi};
            mplier_q <= x_bi;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= StWork;
            state_o  <= ST_WORK;
          end
        end
        StWork: begin
          mcand_q  <= mcand_nxt;
          mplier_q <= mplier_nxt;
          acc_q    <= acc_nxt;
          cnt_q    <= cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            y_bo    <= acc_nxt;
            state_q <= StDone;
            state_o <= ST_DONE;
          end
        end
        default: begin
          state_q <= StReady;
          state_o <= ST_READY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_square.sv
// Directed self-checking bench for the squarer: timing of state_o, held
// results, start/operand changes during WORK, reset abort and back-to-back use.
module tb_square;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] x;
  logic [63:0] y;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;
  logic [63:0] prev;

  square #(
    .WIDTH (32)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .x_bi    (x),
    .y_bo    (y),
    .state_o (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full operation: accept, 31 WORK cycles with junk on the inputs, then DONE.
  task automatic run_op(input logic [31:0] xv, input logic [63:0] exp, input string tag);
    x = xv;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_accept_state"}, 64'(state), 64'd1);
    check({tag, "_accept_hold"}, y, prev);
    for (int i = 1; i < 32; i++) begin
      x = $urandom;
      start = 1'($urandom);
      tick();
      check({tag, "_work_state"}, 64'(state), 64'd1);
      check({tag, "_work_hold"}, y, prev);
    end
    start = 1'b0;
    tick();
    check({tag, "_done_state"}, 64'(state), 64'd2);
    check({tag, "_result"}, y, exp);
    prev = exp;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    x = 32'd0;
    prev = 64'd0;
    tick();
    tick();
    check("reset_state", 64'(state), 64'd0);
    check("reset_y", y, 64'd0);
    rst = 1'b0;
    tick();
    check("idle_state", 64'(state), 64'd0);

    run_op(32'd0, 64'd0, "zero");
    run_op(32'd3, 64'd9, "three");

    // DONE holds indefinitely without start.
    repeat (5) tick();
    check("done_hold_state", 64'(state), 64'd2);
    check("done_hold_y", y, 64'd9);

    run_op(32'd12, 64'd144, "twelve");
    run_op(32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "max");
    run_op(32'h0001_0000, 64'h0000_0001_0000_0000, "pow16");
    run_op(32'h8000_0000, 64'h4000_0000_0000_0000, "msb");
    run_op(32'd1, 64'd1, "one");
    run_op(32'd65535, 64'h0000_0000_FFFE_0001, "ffff");

    // Start held high: a new result every 33 cycles.
    x = 32'd5;
    start = 1'b1;
    tick();
    check("held_accept1", 64'(state), 64'd1);
    x = 32'd6;
    for (int i = 1; i < 32; i++) begin
      tick();
      check("held_work1", 64'(state), 64'd1);
    end
    tick();
    check("held_done1_state", 64'(state), 64'd2);
    check("held_done1_y", y, 64'd25);
    tick();
    check("held_accept2", 64'(state), 64'd1);
    check("held_accept2_hold", y, 64'd25);
    x = 32'd9;
    for (int i = 1; i < 32; i++) begin
      tick();
      check("held_work2", 64'(state), 64'd1);
    end
    start = 1'b0;
    tick();
    check("held_done2_state", 64'(state), 64'd2);
    check("held_done2_y", y, 64'd36);
    prev = 64'd36;

    // Reset ten cycles into an operation aborts it.
    x = 32'd1000;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    check("abort_pre_state", 64'(state), 64'd1);
    rst = 1'b1;
    tick();
    check("abort_state", 64'(state), 64'd0);
    check("abort_y", y, 64'd0);
    rst = 1'b0;
    repeat (40) tick();
    check("abort_stays_ready", 64'(state), 64'd0);
    check("abort_no_result", y, 64'd0);
    prev = 64'd0;
    run_op(32'd7, 64'd49, "seven");

    // Random operands against an arithmetic reference.
    for (int n = 0; n < 20; n++) begin
      logic [31:0] r;
      r = $urandom;
      run_op(r, 64'(r) * 64'(r), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/square.md
Name: square

Overview:
- Iterative integer squarer, y = x*x. It is the inverse companion of the integer square-root unit and uses the same start/state handshake.
- Computes the unsigned square of a WIDTH-bit operand with a shift-add multiplier that retires one multiplier bit per clock.
- Used to check square-root results (square(root(x)) <= x) and wherever the FEC datapath needs x^2 with no hard multiplier.

Parameters:
- WIDTH, 32, operand width in bits. Legal range 2..32. The result is 2*WIDTH bits.

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  start request; sampled in READY or DONE only.
- x_bi  input  WIDTH  unsigned operand; sampled on the accepting edge only.
- y_bo  output  2*WIDTH  unsigned square; valid while state_o = 2.
- state_o  output  3  status: 0 = ready, 1 = work, 2 = done (wait). Values 3..7 are never driven.

Behaviour:
- Reset: rst_i is synchronous, active-high and overrides everything, including an operation in progress.
  - state <= READY, state_o <= 0, y_bo <= 0.
  - Internal mcand, mplier, acc and cnt <= 0.
  - Reset mid-WORK aborts the operation; no partial result reaches y_bo.
- Internal registers:
  - mcand: 2*WIDTH bits, multiplicand, shifted left each step.
  - mplier: WIDTH bits, shifted right each step.
  - acc: 2*WIDTH bits, accumulator.
  - cnt: clog2(WIDTH+1) bits, step counter.
- READY:
  - If start_i = 0, nothing changes.
  - If start_i = 1 on an edge (the accepting edge): mcand <= zero-extended x_bi; mplier <= x_bi; acc <= 0; cnt <= 0; state <= WORK; state_o <= 1.
- WORK, one step per edge:
  - If mplier[0] = 1, acc <= acc + mcand. The sum is 2*WIDTH bits and cannot overflow, since x^2 < 2^(2*WIDTH).
  - mcand <= mcand << 1; mplier <= mplier >> 1; cnt <= cnt + 1.
  - On the step where cnt = WIDTH-1: y_bo <= final acc (including that step's add), state <= DONE, state_o <= 2.
  - start_i and x_bi are ignored throughout WORK. x_bi changes after acceptance have no effect.
  - y_bo keeps the previous result (or 0 after reset) throughout WORK.
- Latency:
  - Accepting edge at k; WORK steps on edges k+1 .. k+WIDTH.
  - state_o = 1 after edges k .. k+WIDTH-1.
  - state_o = 2 and y_bo valid after edge k+WIDTH: exactly WIDTH cycles, independent of operand value (no early exit).
- DONE:
  - y_bo and state_o = 2 are held indefinitely.
  - start_i = 1 is accepted exactly as in READY: state_o <= 1, y_bo still holds the old result until the new one completes. This gives back-to-back operation with no return to READY.
- No other exits from DONE except rst_i.
- Any illegal internal state encoding goes to READY with state_o <= 0 on the next edge.
- start_i held high continuously gives one operation every WIDTH+1 cycles: WIDTH WORK cycles plus one DONE cycle that re-accepts.

Decomposition:
- Shared package fec_pkg holds:
  - state encodings ST_READY = 0, ST_WORK = 1, ST_DONE = 2 (also the state_o codes), shared with the square-root unit;
  - DEFAULT_WIDTH = 32.
- Optional sub-module square_step: combinational single shift-add step; inputs mcand, mplier, acc; outputs next values. It lets a future unrolled variant reuse the step.
- Everything else lives in square.

Test Plan:
- Reset, then x_bi = 0, start one cycle -> state_o = 1 for 32 cycles, then state_o = 2, y_bo = 0.
- x_bi = 3, start -> y_bo = 9 exactly 32 edges after the accepting edge. Toggling x_bi and start_i during WORK changes nothing.
- x_bi = 32'hFFFF_FFFF -> y_bo = 64'hFFFF_FFFE_0000_0001. x_bi = 32'h0001_0000 -> y_bo = 64'h0000_0001_0000_0000.
- rst_i asserted 10 cycles into an operation with x_bi = 1000 -> next edge state_o = 0, y_bo = 0. A new start with x_bi = 7 -> y_bo = 49.
- In DONE holding y_bo = 9, start with x_bi = 12 -> y_bo stays 9 during WORK, then becomes 144 with state_o = 2. Start held high -> results every 33 cycles.
- Random x_bi, chained with the square-root unit: r = root(x), then square(r) <= x < square(r+1) for 1000 random operands.
